// File: rtl/game_pkg.sv
// Shared game-flow types and default constants for the sequencer and HUD/sprite logic.
package game_pkg;

    typedef enum logic [2:0] {
        TITLE     = 3'd0,
        PLAYING   = 3'd1,
        PAUSED    = 3'd2,
        DYING     = 3'd3,
        WIN       = 3'd4,
        GAME_OVER = 3'd5
    } gstate_t;

    localparam logic [7:0]  DEF_KEY_ENTER    = 8'h28;
    localparam logic [7:0]  DEF_KEY_PAUSE    = 8'h13;
    localparam int unsigned DEF_LIVES_INIT   = 3;
    localparam int unsigned DEF_DEATH_FRAMES = 60;
    localparam int unsigned DEF_WIN_FRAMES   = 120;

    // Bits needed to hold a countdown of the longer of the two phases (at least 1).
    function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/key_edge_det.sv
// Registered rising-edge pulse for one keycode seen on either USB keycode slot.
module key_edge_det #(
    parameter logic [7:0] CODE = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] keycode,
    input  logic [7:0] keycode2,
    output logic       rise
);

    logic pressed_c;
    logic prev;

    assign pressed_c = (keycode == CODE) || (keycode2 == CODE);

    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 1'b0;
            rise <= 1'b0;
        end else begin
            prev <= pressed_c;
            rise <= pressed_c & ~prev;
        end
    end

endmodule

// File: rtl/game_flow_ctrl.sv
// Frame-rate game phase sequencer: lives, level, player gating and respawn pulse.
// Define GAME_FLOW_EXTRA_LIFE_EN to award a life (capped at 3) on each level clear.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int unsigned LIVES_INIT   = DEF_LIVES_INIT,
    parameter int unsigned DEATH_FRAMES = DEF_DEATH_FRAMES,
    parameter int unsigned WIN_FRAMES   = DEF_WIN_FRAMES,
    parameter logic [7:0]  KEY_ENTER    = DEF_KEY_ENTER,
    parameter logic [7:0]  KEY_PAUSE    = DEF_KEY_PAUSE
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic [7:0] keycode2,
    input  logic       colliding,
    input  logic       fell,
    input  logic       reached_goal,
    output logic       player_run,
    output logic       player_respawn,
    output logic [1:0] lives,
    output logic [1:0] level,
    output logic [2:0] game_state
);

    localparam int unsigned TW = timer_width(DEATH_FRAMES, WIN_FRAMES);

    gstate_t       state;
    logic [TW-1:0] timer;
    logic          enter_rise;
    logic          pause_rise;

    key_edge_det #(.CODE(KEY_ENTER)) u_enter (
        .clk      (frame_clk),
        .rst      (Reset),
        .keycode  (keycode),
        .keycode2 (keycode2),
        .rise     (enter_rise)
    );

    key_edge_det #(.CODE(KEY_PAUSE)) u_pause (
        .clk      (frame_clk),
        .rst      (Reset),
        .keycode  (keycode),
        .keycode2 (keycode2),
        .rise     (pause_rise)
    );

    assign game_state = state;

    // player_run tracks the next state so it is high on exactly the PLAYING frames.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state          <= TITLE;
            lives          <= 2'(LIVES_INIT);
            level          <= 2'd0;
            timer          <= '0;
            player_run     <= 1'b0;
            player_respawn <= 1'b0;
        end else begin
            player_respawn <= 1'b0;
            unique case (state)
                TITLE: begin
                    if (enter_rise) begin
                        state          <= PLAYING;
                        lives          <= 2'(LIVES_INIT);
                        level          <= 2'd0;
                        player_run     <= 1'b1;
                        player_respawn <= 1'b1;
                    end
                end
                PLAYING: begin
                    if (colliding || fell) begin
                        state      <= DYING;
                        lives      <= (lives == 2'd0) ? 2'd0 : lives - 2'd1;
                        timer      <= TW'(DEATH_FRAMES - 1);
                        player_run <= 1'b0;
                    end else if (reached_goal) begin
                        state      <= WIN;
                        timer      <= TW'(WIN_FRAMES - 1);
                        player_run <= 1'b0;
                    end else if (pause_rise) begin
                        state      <= PAUSED;
                        player_run <= 1'b0;
                    end
                end
                PAUSED: begin
                    if (pause_rise) begin
                        state      <= PLAYING;
                        player_run <= 1'b1;
                    end
                end
                DYING: begin
                    if (timer == '0) begin
                        if (lives == 2'd0) begin
                            state <= GAME_OVER;
                        end else begin
                            state          <= PLAYING;
                            player_run     <= 1'b1;
                            player_respawn <= 1'b1;
                        end
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                WIN: begin
                    if (timer == '0) begin
                        state          <= PLAYING;
                        level          <= level + 2'd1;
                        player_run     <= 1'b1;
                        player_respawn <= 1'b1;
`ifdef GAME_FLOW_EXTRA_LIFE_EN
                        lives          <= (lives == 2'd3) ? 2'd3 : lives + 2'd1;
`endif
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                GAME_OVER: begin
                    if (enter_rise) begin
                        state <= TITLE;
                    end
                end
                default: begin
                    state      <= TITLE;
                    player_run <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl: directed vector table, phase-length sequences, random run.
module tb_game_flow_ctrl;
    import game_pkg::*;

    localparam int unsigned LIVES_INIT   = 3;
    localparam int unsigned DEATH_FRAMES = 60;
    localparam int unsigned WIN_FRAMES   = 120;
    localparam logic [7:0]  K_ENTER      = 8'h28;
    localparam logic [7:0]  K_PAUSE      = 8'h13;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] kc, kc2;
    logic       coll, fell, goal;
    logic       run, resp;
    logic [1:0] lives, level;
    logic [2:0] gs;

    int checks = 0;
    int errors = 0;

    game_flow_ctrl #(
        .LIVES_INIT(LIVES_INIT), .DEATH_FRAMES(DEATH_FRAMES), .WIN_FRAMES(WIN_FRAMES),
        .KEY_ENTER(K_ENTER), .KEY_PAUSE(K_PAUSE)
    ) dut (
        .frame_clk(clk), .Reset(rst), .keycode(kc), .keycode2(kc2),
        .colliding(coll), .fell(fell), .reached_goal(goal),
        .player_run(run), .player_respawn(resp), .lives(lives), .level(level),
        .game_state(gs)
    );

    always #5 clk = ~clk;

    // Reference model: phases with a frames-remaining count, keys act one frame after first seen.
    gstate_t m_state;
    int      m_left, m_lives, m_level;
    bit      m_resp, e_hist, p_hist, e_fire, p_fire;

    task automatic model_step(input logic [7:0] k1, input logic [7:0] k2,
                              input logic c, input logic f, input logic g, input logic r);
        bit e_key, p_key, e_now, p_now;
        e_key = (k1 == K_ENTER) || (k2 == K_ENTER);
        p_key = (k1 == K_PAUSE) || (k2 == K_PAUSE);
        if (r) begin
            m_state = TITLE; m_lives = LIVES_INIT; m_level = 0; m_left = 0; m_resp = 0;
            e_hist = 0; p_hist = 0; e_fire = 0; p_fire = 0;
            return;
        end
        e_now = e_fire; p_now = p_fire;
        e_fire = e_key && !e_hist; e_hist = e_key;
        p_fire = p_key && !p_hist; p_hist = p_key;
        m_resp = 0;
        case (m_state)
            TITLE: if (e_now) begin
                m_state = PLAYING; m_lives = LIVES_INIT; m_level = 0; m_resp = 1;
            end
            PLAYING: begin
                if (c || f) begin
                    m_state = DYING; m_lives = (m_lives > 0) ? m_lives - 1 : 0; m_left = DEATH_FRAMES;
                end else if (g) begin
                    m_state = WIN; m_left = WIN_FRAMES;
                end else if (p_now) begin
                    m_state = PAUSED;
                end
            end
            PAUSED: if (p_now) m_state = PLAYING;
            DYING: begin
                m_left--;
                if (m_left == 0) begin
                    if (m_lives == 0) m_state = GAME_OVER;
                    else begin m_state = PLAYING; m_resp = 1; end
                end
            end
            WIN: begin
                m_left--;
                if (m_left == 0) begin
                    m_state = PLAYING; m_level = (m_level + 1) % 4; m_resp = 1;
`ifdef GAME_FLOW_EXTRA_LIFE_EN
                    m_lives = (m_lives >= 3) ? 3 : m_lives + 1;
`endif
                end
            end
            GAME_OVER: if (e_now) m_state = TITLE;
            default: m_state = TITLE;
        endcase
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One frame: apply inputs, let the edge pass, compare every output against the model.
    task automatic tick(input logic [7:0] k1, input logic [7:0] k2,
                        input logic c, input logic f, input logic g, input logic r);
        kc = k1; kc2 = k2; coll = c; fell = f; goal = g; rst = r;
        @(posedge clk);
        #1;
        model_step(k1, k2, c, f, g, r);
        chk("state", int'(gs), int'(m_state));
        chk("run", int'(run), int'(m_state == PLAYING));
        chk("respawn", int'(resp), int'(m_resp));
        chk("lives", int'(lives), m_lives);
        chk("level", int'(level), m_level);
    endtask

    // Caller has just observed the first frame of phase s; counts frames until it leaves.
    task automatic count_phase(input gstate_t s, input int coll_frames, output int frames);
        frames = 1;
        for (int i = 0; i < 400; i++) begin
            tick(8'h00, 8'h00, 1'(i < coll_frames), 1'b0, 1'b0, 1'b0);
            if (gs != s) return;
            frames++;
        end
        checks++; errors++;
        $display("FAIL timeout: stuck in state %0d expected exit", gs);
    endtask

    task automatic start_game();
        tick(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(K_ENTER, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(K_ENTER, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("start_state", int'(gs), int'(PLAYING));
    endtask

    typedef struct {
        logic [7:0] k1, k2;
        logic       c, f, g, r;
        gstate_t    st;
        logic       run, resp;
        int         lives, level;
    } vec_t;

    vec_t tbl[15];

    initial begin
        int fr, lives_before;
        rst = 1'b1; kc = 8'h00; kc2 = 8'h00; coll = 1'b0; fell = 1'b0; goal = 1'b0;

        tbl[0]  = '{8'h00,   8'h00,   1'b0, 1'b0, 1'b0, 1'b1, TITLE,   1'b0, 1'b0, 3, 0};
        tbl[1]  = '{K_ENTER, 8'h00,   1'b0, 1'b0, 1'b0, 1'b0, TITLE,   1'b0, 1'b0, 3, 0};
        tbl[2]  = '{K_ENTER, 8'h00,   1'b0, 1'b0, 1'b0, 1'b0, PLAYING, 1'b1, 1'b1, 3, 0};
        tbl[3]  = '{K_ENTER, 8'h00,   1'b0, 1'b0, 1'b0, 1'b0, PLAYING, 1'b1, 1'b0, 3, 0};
        tbl[4]  = '{8'h00,   K_ENTER, 1'b0, 1'b0, 1'b0, 1'b0, PLAYING, 1'b1, 1'b0, 3, 0};
        tbl[5]  = '{K_ENTER, 8'h00,   1'b0, 1'b0, 1'b0, 1'b0, PLAYING, 1'b1, 1'b0, 3, 0};
        tbl[6]  = '{8'h00,   8'h00,   1'b0, 1'b0, 1'b0, 1'b0, PLAYING, 1'b1, 1'b0, 3, 0};
        tbl[7]  = '{8'h00,   K_PAUSE, 1'b0, 1'b0, 1'b0, 1'b0, PLAYING, 1'b1, 1'b0, 3, 0};
        tbl[8]  = '{8'h00,   K_PAUSE, 1'b0, 1'b0, 1'b0, 1'b0, PAUSED,  1'b0, 1'b0, 3, 0};
        tbl[9]  = '{8'h00,   K_PAUSE, 1'b1, 1'b0, 1'b0, 1'b0, PAUSED,  1'b0, 1'b0, 3, 0};
        tbl[10] = '{8'h00,   8'h00,   1'b1, 1'b0, 1'b1, 1'b0, PAUSED,  1'b0, 1'b0, 3, 0};
        tbl[11] = '{K_PAUSE, 8'h00,   1'b0, 1'b0, 1'b0, 1'b0, PAUSED,  1'b0, 1'b0, 3, 0};
        tbl[12] = '{8'h00,   8'h00,   1'b0, 1'b0, 1'b0, 1'b0, PLAYING, 1'b1, 1'b0, 3, 0};
        tbl[13] = '{8'h00,   8'h00,   1'b1, 1'b0, 1'b1, 1'b0, DYING,   1'b0, 1'b0, 2, 0};
        tbl[14] = '{8'h00,   8'h00,   1'b0, 1'b1, 1'b0, 1'b0, DYING,   1'b0, 1'b0, 2, 0};

        for (int i = 0; i < 15; i++) begin
            tick(tbl[i].k1, tbl[i].k2, tbl[i].c, tbl[i].f, tbl[i].g, tbl[i].r);
            chk($sformatf("vec%0d_state", i), int'(gs), int'(tbl[i].st));
            chk($sformatf("vec%0d_run", i), int'(run), int'(tbl[i].run));
            chk($sformatf("vec%0d_resp", i), int'(resp), int'(tbl[i].resp));
            chk($sformatf("vec%0d_lives", i), int'(lives), tbl[i].lives);
            chk($sformatf("vec%0d_level", i), int'(level), tbl[i].level);
        end

        // Death with collision held 10 frames: one life lost, exact DYING length, respawn.
        start_game();
        tick(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        count_phase(DYING, 9, fr);
        chk("death_frames", fr, DEATH_FRAMES);
        chk("death_lives", int'(lives), 2);
        chk("death_exit_state", int'(gs), int'(PLAYING));
        chk("death_respawn", int'(resp), 1);

        // Remaining deaths lead to GAME_OVER; ENTER returns to TITLE.
        for (int d = 0; d < 3 && gs == PLAYING; d++) begin
            tick(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
            count_phase(DYING, 0, fr);
        end
        chk("gameover_state", int'(gs), int'(GAME_OVER));
        chk("gameover_lives", int'(lives), 0);
        tick(8'h00, K_ENTER, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(8'h00, K_ENTER, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("gameover_to_title", int'(gs), int'(TITLE));

        // Four level clears after one death: level wraps 3->0, lives follow the extra-life option.
        start_game();
        tick(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        count_phase(DYING, 0, fr);
        for (int w = 0; w < 4; w++) begin
            tick(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
            count_phase(WIN, 0, fr);
            chk("win_frames", fr, WIN_FRAMES);
            chk("win_level", int'(level), (w + 1) % 4);
            chk("win_respawn", int'(resp), 1);
        end
`ifdef GAME_FLOW_EXTRA_LIFE_EN
        chk("win_lives", int'(lives), 3);
`else
        chk("win_lives", int'(lives), 2);
`endif

        // Reset while dying restores the title defaults.
        tick(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("reset_dying_state", int'(gs), int'(TITLE));
        chk("reset_dying_lives", int'(lives), 3);

        // Random frames against the model.
        for (int n = 0; n < 4000; n++) begin
            logic [7:0] ka, kb;
            int sel;
            sel = $urandom_range(0, 9);
            ka = (sel < 2) ? K_ENTER : (sel < 4) ? K_PAUSE : (sel < 5) ? 8'($urandom) : 8'h00;
            sel = $urandom_range(0, 9);
            kb = (sel < 1) ? K_ENTER : (sel < 2) ? K_PAUSE : 8'h00;
            tick(ka, kb, 1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 59) == 0),
                 1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 999) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
